r16_fft_ctrl: RTL and testbench

// Top-level sequencer for the radix-16 FFT datapath. Runs one transform per start:

---
 rtl/r16_fft_ctrl_if.sv | 30 +++
 rtl/r16_fft_ctrl.sv | 149 ++++++++++++++
 tb/tb_r16_fft_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/r16_fft_ctrl_if.sv
// Control/handshake bundle between the FFT sequencer and its environment.
// The master modport is the environment side; the slave modport is the sequencer.
interface r16_fft_ctrl_if #(
    parameter int CNT_WIDTH = 15
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_ready;
    logic                 AGU_en;
    logic                 rc_sel_out;
    logic                 wrfd_en_out;
    logic                 FFT_fin_out;
    logic                 busy;
    logic                 done;
    logic [2:0]           state_out;
    logic [CNT_WIDTH-1:0] phase_cnt;

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_out,
        input  busy, done, state_out, phase_cnt
    );

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_out,
        output busy, done, state_out, phase_cnt
    );
endinterface

// File: rtl/r16_fft_ctrl.sv
// Radix-16 FFT sequencer: LOAD samples, run the AGU FFT pass, drain the
// butterfly pipeline, then read results out through the AGU in rc_sel mode.
module r16_fft_ctrl #(
    parameter int N_POINTS   = 4096,
    parameter int FFT_CYCLES = 16432,
    parameter int PIPE_DEPTH = 48,
    parameter int CNT_WIDTH  = 15
) (
    input  logic          clk,
    input  logic          rst,
    r16_fft_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FFT    = 3'd2,
        S_DRAIN  = 3'd3,
        S_UNLOAD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Terminal counts, zero-extended to the counter width.
    localparam logic [CNT_WIDTH-1:0] LOAD_LAST   = CNT_WIDTH'(N_POINTS - 1);
    localparam logic [CNT_WIDTH-1:0] FFT_LAST    = CNT_WIDTH'(FFT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST  = CNT_WIDTH'(PIPE_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOAD_LAST = CNT_WIDTH'(N_POINTS);

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;

    logic in_ready_c;
    logic agu_en_c;
    logic rc_sel_c;
    logic wrfd_en_c;
    logic fft_fin_c;
    logic busy_c;
    logic done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Handshakes: an input beat is in_valid & in_ready (LOAD only); an output
    // beat is out_ready while in UNLOAD. A stalled beat holds phase_cnt.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        in_ready_c = 1'b0;
        agu_en_c   = 1'b0;
        rc_sel_c   = 1'b0;
        wrfd_en_c  = 1'b0;
        fft_fin_c  = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_LOAD;
                    cnt_nx   = '0;
                end
            end

            S_LOAD: begin
                busy_c     = 1'b1;
                in_ready_c = 1'b1;
                wrfd_en_c  = bus.in_valid;
                if (bus.in_valid) begin
                    if (cnt == LOAD_LAST) begin
                        state_nx = S_FFT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end

            S_FFT: begin
                busy_c   = 1'b1;
                agu_en_c = 1'b1;
                if (cnt == FFT_LAST) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            S_DRAIN: begin
                busy_c    = 1'b1;
                fft_fin_c = 1'b1;
                if (cnt == DRAIN_LAST) begin
                    state_nx = S_UNLOAD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            // N_POINTS+1 beats: the extra beat lets the AGU counter wrap to 0.
            S_UNLOAD: begin
                busy_c    = 1'b1;
                fft_fin_c = 1'b1;
                rc_sel_c  = 1'b1;
                agu_en_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (cnt == UNLOAD_LAST) begin
                        state_nx = S_DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end

            S_DONE: begin
                busy_c   = 1'b1;
                done_c   = 1'b1;
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end

            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.AGU_en      = agu_en_c;
    assign bus.rc_sel_out  = rc_sel_c;
    assign bus.wrfd_en_out = wrfd_en_c;
    assign bus.FFT_fin_out = fft_fin_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.state_out   = state;
    assign bus.phase_cnt   = cnt;

endmodule

// File: tb/tb_r16_fft_ctrl.sv
// Bench for r16_fft_ctrl: builds an expected per-cycle trace from the phase
// rules, then drives the recorded stimulus and compares cycle by cycle.
module tb_r16_fft_ctrl;

    localparam int N   = 8;
    localparam int FC  = 20;
    localparam int PD  = 3;
    localparam int CW  = 15;
    localparam int EW  = 3 + CW + 7;

    logic clk;
    logic rst;

    r16_fft_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    r16_fft_ctrl #(
        .N_POINTS  (N),
        .FFT_CYCLES(FC),
        .PIPE_DEPTH(PD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word: {state[2:0], cnt[CW-1:0], in_ready, agu, rc, wrfd, fin, busy, done}
    logic [EW-1:0] exp_q[$];
    logic [3:0]    stim_q[$];   // {rst, start, in_valid, out_ready}

    int n_checks = 0;
    int n_fail   = 0;
    int runs_started   = 0;
    int runs_completed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_cyc(input logic r, input logic s, input logic v, input logic o_rdy,
                            input logic [2:0] st, input int cnt, input logic [6:0] o);
        stim_q.push_back({r, s, v, o_rdy});
        exp_q.push_back({st, CW'(cnt), o});
    endtask

    // mode: 0 all-ones, 1 in_valid 0101.., 2 random, 3 out_ready stall of 5 mid-UNLOAD
    task automatic build_run(input int mode, input int abort_at);
        int   beats;
        int   i;
        logic v;
        logic r;
        runs_started++;
        push_cyc(1'b0, 1'b1, rb(), rb(), 3'd0, 0, 7'b0);

        beats = 0;
        i = 0;
        while (beats < N) begin
            case (mode)
                1:       v = (i % 2 == 1);
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            push_cyc(1'b0, rb(), v, rb(), 3'd1, beats, {1'b1, 1'b0, 1'b0, v, 1'b0, 1'b1, 1'b0});
            beats += int'(v);
            i++;
        end

        for (int f = 0; f < FC; f++) begin
            if (f == abort_at) begin
                push_cyc(1'b1, rb(), rb(), rb(), 3'd2, f, 7'b0100010);
                for (int k = 0; k < 3; k++)
                    push_cyc(1'b0, 1'b0, rb(), rb(), 3'd0, 0, 7'b0);
                return;
            end
            push_cyc(1'b0, rb(), rb(), rb(), 3'd2, f, 7'b0100010);
        end

        for (int d = 0; d < PD; d++)
            push_cyc(1'b0, rb(), rb(), rb(), 3'd3, d, 7'b0000110);

        beats = 0;
        i = 0;
        while (beats <= N) begin
            case (mode)
                2:       r = ($urandom_range(0, 2) != 0);
                3:       r = !(i >= 3 && i < 8);
                default: r = 1'b1;
            endcase
            push_cyc(1'b0, rb(), rb(), r, 3'd4, beats, {1'b0, r, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
            beats += int'(r);
            i++;
        end

        push_cyc(1'b0, rb(), rb(), rb(), 3'd5, 0, 7'b0000011);
        runs_completed++;
    endtask

    task automatic drive_all();
        logic [3:0]    s;
        logic [EW-1:0] e;
        int wrfd_seen = 0;
        int agu_unload_seen = 0;
        int done_seen = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            rst           = s[3];
            bus.start     = s[2];
            bus.in_valid  = s[1];
            bus.out_ready = s[0];
            #1;
            check("state", 32'(bus.state_out), 32'(e[EW-1 -: 3]));
            check("phase_cnt", 32'(bus.phase_cnt), 32'(e[CW+6:7]));
            check("outputs", 32'({bus.in_ready, bus.AGU_en, bus.rc_sel_out, bus.wrfd_en_out,
                                  bus.FFT_fin_out, bus.busy, bus.done}), 32'(e[6:0]));
            wrfd_seen += int'(bus.wrfd_en_out);
            done_seen += int'(bus.done);
            if (e[EW-1 -: 3] == 3'd4)
                agu_unload_seen += int'(bus.AGU_en);
        end
        check("wrfd_total", 32'(wrfd_seen), 32'(N * runs_started));
        check("agu_unload_total", 32'(agu_unload_seen), 32'((N + 1) * runs_completed));
        check("done_total", 32'(done_seen), 32'(runs_completed));
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(bus.state_out), 32'd0);
        check("reset_cnt", 32'(bus.phase_cnt), 32'd0);
        check("reset_outputs", 32'({bus.in_ready, bus.AGU_en, bus.rc_sel_out, bus.wrfd_en_out,
                                    bus.FFT_fin_out, bus.busy, bus.done}), 32'd0);

        push_cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 0, 7'b0);
        build_run(0, -1);
        build_run(1, -1);
        build_run(3, -1);
        build_run(0, 10);
        for (int k = 0; k < 3; k++)
            build_run(2, -1);
        for (int k = 0; k < 3; k++)
            push_cyc(1'b0, 1'b0, rb(), rb(), 3'd0, 0, 7'b0);

        drive_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
